prog_counter_modal: RTL and testbench
=====================================

PROG_COUNTER_MODAL -- requirements
Module: prog_counter_modal

Interface
REQ-001 Parameter WIDTH, default 16, counter/limit width; legal range 8..16.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  project-select; when 0, all state holds, writes ignored.
REQ-005 ui_in  input  8  write data byte.
REQ-006 uio_in  input  8  control: [0] WR strobe, [2:1] ADDR, [3] EN count-enable, [4] SEL output byte select, [7:5] ignored.
REQ-007 uo_out  output  8  SEL=0: count[7:0]; SEL=1: count[WIDTH-1:8] zero-extended (0 when WIDTH=8).
REQ-008 uio_out  output  8  [4:0] constant 0; [5] TC pulse; [6] DONE; [7] DIR (1 = mode is a down mode).
REQ-009 uio_oe  output  8  constant 8'hE0 (bits [7:5] driven, [4:0] inputs).

Function
REQ-010 Registers: count[WIDTH], LIMIT[WIDTH], MODE[2], PRESC[4], psc[4], tc, done.
REQ-011 Write (ena=1, WR=1), by ADDR: 0 LIMIT[7:0]<=ui_in; 1 LIMIT[WIDTH-1:8]<=ui_in low bits, excess bits dropped, no effect when WIDTH=8; 2 MODE<=ui_in[1:0], PRESC<=ui_in[5:2], psc<=0; 3 START.
REQ-012 START: count<=0 in modes 0/1, count<=LIMIT in modes 2/3; psc<=0; done<=0; mode 3 with LIMIT=0 sets done<=1 instead, no TC.
REQ-013 LIMIT/MODE writes never modify count.
REQ-014 Running = !(MODE==3 && done).
REQ-015 Tick cycle: ena=1, WR=0, EN=1, running; on a tick, psc==PRESC gives psc<=0 plus one count step; otherwise psc<=psc+1 and no step.
REQ-016 Cycle with WR=1: no step, psc unchanged except ADDR 2/3 clear.
REQ-017 Mode 0 free-run up: count+1 modulo 2^WIDTH; terminal event on all-ones->0.
REQ-018 Mode 1 modulo up: count>=LIMIT steps to 0 (terminal event), else count+1; count>LIMIT after LIMIT change wraps to 0 on next step.
REQ-019 Mode 2 down auto-reload: count==0 steps to LIMIT (terminal event), else count-1.
REQ-020 Mode 3 one-shot down: count-1; step 1->0 is terminal event and sets done<=1; count then holds until START/reset.
REQ-021 tc registered: high exactly one cycle after the edge performing a terminal event, else 0; never high two consecutive cycles unless consecutive terminal events (PRESC=0, LIMIT=0 in modes 1/2).
REQ-022 done clears only on START or reset; MODE write leaves done unchanged.
REQ-023 DIR = MODE[1], combinational from register.
REQ-024 All outputs driven directly from registers/constants; no combinational path ui_in->outputs.

Reset
REQ-025 rst_n low: immediately count=0, LIMIT=all-ones, MODE=0, PRESC=0, psc=0, tc=0, done=0, independent of clk.
REQ-026 During reset: uo_out=0, uio_out=0, uio_oe=8'hE0; first step possible at first tick edge after rst_n rises.

Verification
REQ-027 Reset, WIDTH=16, EN=1, SEL toggled: after 256 ticks low byte 0x00, high byte 0x01; after 65536 ticks count=0, TC high one cycle.
REQ-028 Mode 1, LIMIT=5, START, EN=1: count 0,1,2,3,4,5,0,1; TC high only in cycle after 5->0.
REQ-029 Mode 2, LIMIT=3, PRESC=2, START: count 3 held 3 cycles each, sequence 3,2,1,0,3; TC after 0->3; DIR=1.
REQ-030 Mode 3, LIMIT=2, START: 2,1,0, done=1, one TC; 10 more EN cycles count stays 0; START -> count 2, done=0.
REQ-031 Count at 0x1234 mode 0, rst_n pulsed low between edges: uo_out 0 before next edge, uio_oe 8'hE0, LIMIT reads back all-ones behaviour (mode 1 counts to 0xFFFF).
REQ-032 WR=1 with EN=1 for 3 cycles: count unchanged; ena=0 with WR/EN active: no register changes.

Source files
------------

// File: rtl/prog_counter_modal.sv
// Programmable counter with four counting modes (free-run up, modulo up,
// down auto-reload, one-shot down), a 4-bit prescaler, and a byte-wide
// register interface. The count is read a byte at a time through uo_out.
module prog_counter_modal #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_limit;
    logic [1:0]       r_mode;
    logic [3:0]       r_presc;
    logic [3:0]       r_psc;
    logic             r_tc;
    logic             r_done;

    logic             w_wr;
    logic [1:0]       w_addr;
    logic             w_en;
    logic             w_sel;
    logic             w_running;
    logic             w_tick;
    logic             w_step;
    logic [WIDTH-1:0] w_next;
    logic             w_term;
    logic [15:0]      w_cnt16;
    logic [15:0]      w_lim16;
    logic [15:0]      w_lim_wide;
    logic [WIDTH-1:0] w_lim_hi_new;
    logic             w_unused_bits;

    assign w_wr      = ena & uio_in[0];
    assign w_addr    = uio_in[2:1];
    assign w_en      = uio_in[3];
    assign w_sel     = uio_in[4];
    assign w_running = !((r_mode == 2'd3) && r_done);
    assign w_tick    = ena & ~uio_in[0] & w_en & w_running;
    assign w_step    = w_tick & (r_psc == r_presc);

    // Zero-extended views so the byte-wide paths work for any WIDTH in 8..16;
    // bits above WIDTH in the high-byte write simply fall off.
    assign w_cnt16       = 16'(r_count);
    assign w_lim16       = 16'(r_limit);
    assign w_lim_wide    = {ui_in, w_lim16[7:0]};
    assign w_lim_hi_new  = w_lim_wide[WIDTH-1:0];
    assign w_unused_bits = &{1'b0, uio_in[7:5], w_lim16[15:8]};

    // Next count value and terminal-event flag for one step in the current mode.
    always_comb begin
        w_next = r_count;
        w_term = 1'b0;
        case (r_mode)
            2'd0: begin
                w_next = r_count + 1'b1;
                w_term = (r_count == ONES);
            end
            2'd1: begin
                if (r_count >= r_limit) begin
                    w_next = '0;
                    w_term = 1'b1;
                end else begin
                    w_next = r_count + 1'b1;
                end
            end
            2'd2: begin
                if (r_count == '0) begin
                    w_next = r_limit;
                    w_term = 1'b1;
                end else begin
                    w_next = r_count - 1'b1;
                end
            end
            default: begin
                w_next = r_count - 1'b1;
                w_term = (r_count == WIDTH'(1));
            end
        endcase
    end

    // Register writes, START, prescaler and counting; a write cycle never steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_limit <= ONES;
            r_mode  <= 2'd0;
            r_presc <= 4'd0;
            r_psc   <= 4'd0;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (w_wr) begin
                case (w_addr)
                    2'd0: r_limit[7:0] <= ui_in;
                    2'd1: r_limit      <= w_lim_hi_new;
                    2'd2: begin
                        r_mode  <= ui_in[1:0];
                        r_presc <= ui_in[5:2];
                        r_psc   <= 4'd0;
                    end
                    default: begin
                        r_psc <= 4'd0;
                        if (!r_mode[1]) begin
                            r_count <= '0;
                            r_done  <= 1'b0;
                        end else begin
                            r_count <= r_limit;
                            // A one-shot with nothing to count is finished at once.
                            r_done  <= (r_mode == 2'd3) && (r_limit == '0);
                        end
                    end
                endcase
            end else if (w_tick) begin
                if (w_step) begin
                    r_psc   <= 4'd0;
                    r_count <= w_next;
                    r_tc    <= w_term;
                    if ((r_mode == 2'd3) && w_term) begin
                        r_done <= 1'b1;
                    end
                end else begin
                    r_psc <= r_psc + 1'b1;
                end
            end
        end
    end

    assign uo_out  = w_sel ? w_cnt16[15:8] : w_cnt16[7:0];
    assign uio_out = {r_mode[1], r_done, r_tc, 5'b00000};
    assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_prog_counter_modal.sv
// Self-checking bench for prog_counter_modal (WIDTH=16). Each driven cycle
// pushes its expected count/tc/done to a queue; the entry is popped and
// compared once the DUT has updated after the clock edge.
module tb_prog_counter_modal;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic       t_wr;
    logic [1:0] t_addr;
    logic       t_en;
    logic       t_sel;

    int n_total;
    int n_bad;

    typedef struct {
        string       tag;
        logic [15:0] cnt;
        logic        tc;
        logic        done;
    } exp_t;

    exp_t q_exp[$];

    assign uio_in = {3'b000, t_sel, t_en, t_addr, t_wr};

    prog_counter_modal #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic wr, input logic [1:0] addr, input logic [7:0] data,
                         input logic en);
        t_wr   = wr;
        t_addr = addr;
        ui_in  = data;
        t_en   = en;
    endtask

    // One clock: queue the expectation, let the edge happen, then read both bytes.
    task automatic cyc(input string tag, input logic [15:0] cnt, input logic tc,
                       input logic done);
        exp_t e;
        exp_t got_e;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] flags;
        e.tag = tag; e.cnt = cnt; e.tc = tc; e.done = done;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        flags = uio_out;
        t_sel = 1'b0;
        #1 lo = uo_out;
        t_sel = 1'b1;
        #1 hi = uo_out;
        t_sel = 1'b0;
        got_e = q_exp.pop_front();
        chk({got_e.tag, ".cnt"},  {16'h0, hi, lo},   {16'h0, got_e.cnt});
        chk({got_e.tag, ".tc"},   {31'h0, flags[5]}, {31'h0, got_e.tc});
        chk({got_e.tag, ".done"}, {31'h0, flags[6]}, {31'h0, got_e.done});
    endtask

    task automatic reset_outputs_chk(input string tag);
        t_sel = 1'b0;
        #1 chk({tag, ".lo"}, {24'h0, uo_out}, 32'h0);
        t_sel = 1'b1;
        #1 chk({tag, ".hi"}, {24'h0, uo_out}, 32'h0);
        t_sel = 1'b0;
        chk({tag, ".uio_out"}, {24'h0, uio_out}, 32'h0);
        chk({tag, ".uio_oe"},  {24'h0, uio_oe},  32'hE0);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b1;
        ena     = 1'b1;
        t_sel   = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        #1 rst_n = 1'b0;
        reset_outputs_chk("rst0");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Mode 0 free run from reset: every tick steps, wrap after 65536 ticks.
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        for (int i = 1; i <= 65536; i++) begin
            cyc("m0", 16'(i), (i == 65536), 1'b0);
        end
        chk("m0.dir", {31'h0, uio_out[7]}, 32'h0);

        // Writes with EN=1 never step; mode 1 with LIMIT=5.
        drive(1'b1, 2'd0, 8'h05, 1'b1); cyc("m1.wlo",  16'h0, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 8'h00, 1'b1); cyc("m1.whi",  16'h0, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 8'h01, 1'b1); cyc("m1.wmd",  16'h0, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 8'h00, 1'b1); cyc("m1.start", 16'h0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        cyc("m1.s1", 16'd1, 1'b0, 1'b0);
        cyc("m1.s2", 16'd2, 1'b0, 1'b0);
        cyc("m1.s3", 16'd3, 1'b0, 1'b0);
        cyc("m1.s4", 16'd4, 1'b0, 1'b0);
        cyc("m1.s5", 16'd5, 1'b0, 1'b0);
        cyc("m1.wrap", 16'd0, 1'b1, 1'b0);
        cyc("m1.s7", 16'd1, 1'b0, 1'b0);

        // Mode 2, LIMIT=3, PRESC=2: each value held for three cycles.
        drive(1'b1, 2'd0, 8'h03, 1'b0); cyc("m2.wlo", 16'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 8'h0A, 1'b0); cyc("m2.wmd", 16'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 8'h00, 1'b0); cyc("m2.start", 16'd3, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        begin
            logic [15:0] seq [5];
            seq[0] = 16'd3; seq[1] = 16'd2; seq[2] = 16'd1; seq[3] = 16'd0; seq[4] = 16'd3;
            for (int k = 1; k <= 12; k++) begin
                cyc("m2.run", seq[k / 3], (k == 12), 1'b0);
            end
        end
        chk("m2.dir", {31'h0, uio_out[7]}, 32'h1);
        chk("m2.low5", {27'h0, uio_out[4:0]}, 32'h0);

        // Mode 3 one-shot, LIMIT=2.
        drive(1'b1, 2'd0, 8'h02, 1'b0); cyc("m3.wlo", 16'd3, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 8'h03, 1'b0); cyc("m3.wmd", 16'd3, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 8'h00, 1'b0); cyc("m3.start", 16'd2, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        cyc("m3.s1", 16'd1, 1'b0, 1'b0);
        cyc("m3.end", 16'd0, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cyc("m3.hold", 16'd0, 1'b0, 1'b1);
        end
        drive(1'b1, 2'd2, 8'h03, 1'b0); cyc("m3.mdkeep", 16'd0, 1'b0, 1'b1);
        drive(1'b1, 2'd3, 8'h00, 1'b0); cyc("m3.restart", 16'd2, 1'b0, 1'b0);

        // ena=0 freezes everything, including START and counting.
        ena = 1'b0;
        drive(1'b1, 2'd3, 8'h00, 1'b1); cyc("ena0.wr", 16'd2, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 1'b1); cyc("ena0.en", 16'd2, 1'b0, 1'b0);
        ena = 1'b1;

        // One-shot with LIMIT=0 finishes on START with no TC.
        drive(1'b1, 2'd0, 8'h00, 1'b0); cyc("m3z.wlo", 16'd2, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 8'h00, 1'b0); cyc("m3z.start", 16'd0, 1'b0, 1'b1);
        drive(1'b0, 2'd0, 8'h00, 1'b1); cyc("m3z.hold", 16'd0, 1'b0, 1'b1);

        // Load 0x1234 via a one-shot START, switch to mode 0, then pulse reset.
        drive(1'b1, 2'd0, 8'h34, 1'b0); cyc("r.wlo", 16'd0, 1'b0, 1'b1);
        drive(1'b1, 2'd1, 8'h12, 1'b0); cyc("r.whi", 16'd0, 1'b0, 1'b1);
        drive(1'b1, 2'd3, 8'h00, 1'b0); cyc("r.start", 16'h1234, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 8'h00, 1'b0); cyc("r.wmd", 16'h1234, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 1'b1);
        #1 rst_n = 1'b0;
        reset_outputs_chk("rst1");
        #1 rst_n = 1'b1;
        cyc("r.first", 16'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 8'h02, 1'b1); cyc("r.wmd2", 16'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 8'h00, 1'b1); cyc("r.limff", 16'hFFFF, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 8'h00, 1'b1); cyc("r.dn", 16'hFFFE, 1'b0, 1'b0);
        chk("r.dir", {31'h0, uio_out[7]}, 32'h1);
        chk("q.empty", q_exp.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
